// File: rtl/types_pkg.sv
// Shared types for the integer pipeline hazard controller.
// Scoreboard entry layout and the halt/drain FSM state encoding.
package types_pkg;

    // Scoreboard rd field is sized for the widest register file supported.
    localparam int HZ_AW_MAX = 8;

    typedef struct packed {
        logic                 valid;
        logic                 wr;
        logic [HZ_AW_MAX-1:0] rd;
        logic                 load;
    } hz_entry_t;

    typedef enum logic [1:0] {
        HZ_RUN    = 2'd0,
        HZ_DRAIN  = 2'd1,
        HZ_HALTED = 2'd2
    } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_match.sv
// Priority encoder over the scoreboard for one source operand.
// Returns the youngest matching stage (1-based, 0 = none) and whether it is a load.
module fwd_match
    import types_pkg::*;
#(
    parameter int STAGES       = 3,
    parameter int REG_AW       = 4,
    parameter int R0_HARDWIRED = 0,
    parameter int FW           = $clog2(STAGES + 1)
) (
    input  hz_entry_t [STAGES-1:0] ent,
    input  logic [REG_AW-1:0]      src,
    input  logic                   en,
    output logic [FW-1:0]          sel,
    output logic                   is_load
);

    logic r0_block;
    assign r0_block = (R0_HARDWIRED != 0) && (src == '0);

    // Walk oldest to youngest so the youngest writer overrides.
    always_comb begin
        sel     = '0;
        is_load = 1'b0;
        for (int k = STAGES; k >= 1; k--) begin
            if (en && !r0_block && ent[k-1].valid && ent[k-1].wr &&
                ent[k-1].rd == HZ_AW_MAX'(src)) begin
                sel     = FW'(k);
                is_load = ent[k-1].load;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: per-stage writer scoreboard, operand forwarding
// selects, load-use stall and a run/drain/halted state machine.
module pipe_hazard_ctrl
    import types_pkg::*;
#(
    parameter int STAGES       = 3,
    parameter int REG_AW       = 4,
    parameter int LOAD_READY   = 2,
    parameter int R0_HARDWIRED = 0,
    parameter int CNT_W        = 16,
    parameter int FW           = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic              issue_wr,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic              issue_load,
    input  logic              issue_halt,
    input  logic [REG_AW-1:0] src_a,
    input  logic [REG_AW-1:0] src_b,
    input  logic              src_a_en,
    input  logic              src_b_en,
    input  logic              flush,
    output logic              issue_ack,
    output logic              stall,
    output logic [FW-1:0]     fwd_sel_a,
    output logic [FW-1:0]     fwd_sel_b,
    output logic [STAGES-1:0] stage_valid,
    output logic              draining,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt
);

    hz_entry_t [STAGES-1:0] sb;
    hz_entry_t              ent_new;
    hz_state_e              state, state_nxt;
    logic                   ld_a, ld_b, load_use;

    fwd_match #(.STAGES(STAGES), .REG_AW(REG_AW), .R0_HARDWIRED(R0_HARDWIRED), .FW(FW))
        u_fwd_a (.ent(sb), .src(src_a), .en(src_a_en), .sel(fwd_sel_a), .is_load(ld_a));

    fwd_match #(.STAGES(STAGES), .REG_AW(REG_AW), .R0_HARDWIRED(R0_HARDWIRED), .FW(FW))
        u_fwd_b (.ent(sb), .src(src_b), .en(src_b_en), .sel(fwd_sel_b), .is_load(ld_b));

    // A load is only usable once it reaches stage LOAD_READY.
    assign load_use = (ld_a && fwd_sel_a != '0 && fwd_sel_a < FW'(LOAD_READY)) ||
                      (ld_b && fwd_sel_b != '0 && fwd_sel_b < FW'(LOAD_READY));

    for (genvar k = 0; k < STAGES; k++) begin : g_sv
        assign stage_valid[k] = sb[k].valid;
    end

    assign draining = (state == HZ_DRAIN);
    assign halted   = (state == HZ_HALTED);

    always_comb begin
        state_nxt = state;
        stall     = load_use || (state != HZ_RUN);
        issue_ack = issue_valid && !stall && !flush && (state == HZ_RUN);
        case (state)
            HZ_RUN:    if (issue_ack && issue_halt) state_nxt = HZ_DRAIN;
            HZ_DRAIN:  if (stage_valid == '0) state_nxt = HZ_HALTED;
            HZ_HALTED: state_nxt = HZ_HALTED;
            default:   state_nxt = HZ_RUN;
        endcase
    end

    // HALT itself never occupies a stage.
    always_comb begin
        ent_new       = '0;
        ent_new.valid = issue_ack && !issue_halt;
        ent_new.wr    = issue_wr;
        ent_new.rd    = HZ_AW_MAX'(issue_rd);
        ent_new.load  = issue_load;
        if (!ent_new.valid) ent_new = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb        <= '0;
            state     <= HZ_RUN;
            stall_cnt <= '0;
        end else begin
            sb    <= {sb[STAGES-2:0], ent_new};
            state <= state_nxt;
            if (stall && state == HZ_RUN && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
